// File: rtl/vector_mem_unit.sv
// vector_mem_unit: sequences a V-bit vector load/store as LANES single-lane
// accesses to an N-bit single-port data memory, one access per cycle, with a
// MEM_LAT-deep capture pipeline that assembles load data back into a vector.
//
// state  | meaning
// IDLE   | waiting for start; stall_cpu follows start so the request cycle is held
// ISSUE  | one memory access per cycle, lane 0 up to the last active lane
// DRAIN  | loads only: wait MEM_LAT cycles for the final read to be captured
// DONE   | one-cycle done pulse, load_vector final, start ignored
module vector_mem_unit #(
   parameter int V       = 128,
   parameter int N       = 32,
   parameter int MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_store,
   input  logic         is_vector,
   input  logic [V-1:0] addr_vector,
   input  logic [V-1:0] data_vector,
   input  logic [N-1:0] mem_rdata,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         mem_wen,
   output logic         mem_ren,
   output logic         stall_cpu,
   output logic         done,
   output logic [V-1:0] load_vector
);

   localparam int LANES = V / N;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DW    = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t          state;
   logic [LW-1:0]   lane;
   logic [LW-1:0]   lane_nxt;
   logic [LW-1:0]   last_lane;
   logic [DW-1:0]   drain_cnt;
   logic            store_q;
   logic            vector_q;
   logic [N-1:0]    addr_q [LANES];
   logic [N-1:0]    data_q [LANES];

   logic [MEM_LAT-1:0] pipe_v;
   logic [LW-1:0]      pipe_lane [MEM_LAT];

   assign lane_nxt  = lane + 1'b1;
   assign last_lane = vector_q ? LW'(LANES - 1) : '0;

   // Sequencer: latches operands, walks the lanes and drives registered memory strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         lane      <= '0;
         drain_cnt <= '0;
         store_q   <= 1'b0;
         vector_q  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wen   <= 1'b0;
         mem_ren   <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < LANES; i++) begin
                     addr_q[i] <= addr_vector[i*N +: N];
                     data_q[i] <= data_vector[i*N +: N];
                  end
                  store_q   <= is_store;
                  vector_q  <= is_vector;
                  lane      <= '0;
                  mem_addr  <= addr_vector[N-1:0];
                  mem_wdata <= is_store ? data_vector[N-1:0] : '0;
                  mem_wen   <= is_store;
                  mem_ren   <= !is_store;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (lane == last_lane) begin
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_wen   <= 1'b0;
                  mem_ren   <= 1'b0;
                  drain_cnt <= '0;
                  if (store_q) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else begin
                  lane      <= lane_nxt;
                  mem_addr  <= addr_q[lane_nxt];
                  mem_wdata <= store_q ? data_q[lane_nxt] : '0;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DW'(MEM_LAT - 1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // CPU is held in the request cycle and for the whole access/drain window
   always_comb begin
      stall_cpu = 1'b0;
      case (state)
         S_IDLE:  stall_cpu = start;
         S_ISSUE: stall_cpu = 1'b1;
         S_DRAIN: stall_cpu = 1'b1;
         default: stall_cpu = 1'b0;
      endcase
   end

   // Read-return pipeline: lane tag travels MEM_LAT cycles beside the read, then lands in load_vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v      <= '0;
         load_vector <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe_lane[i] <= '0;
         end
      end else begin
         pipe_v[0]    <= mem_ren;
         pipe_lane[0] <= lane;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_lane[i] <= pipe_lane[i-1];
         end
         if (state == S_IDLE && start) begin
            load_vector <= '0;
         end else if (pipe_v[MEM_LAT-1]) begin
            for (int l = 0; l < LANES; l++) begin
               if (pipe_lane[MEM_LAT-1] == LW'(l)) begin
                  load_vector[l*N +: N] <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: doc/vector_mem_unit.md
Name: vector_mem_unit

Overview:
- Parametrised multi-cycle vector load/store sequencer between the vector register file and the single-port N-bit data memory.
- Splits a V-bit vector into LANES = V/N elements and issues one memory access per cycle, gathering per-lane addresses from an address vector.
- Supports stores, scalar single-lane mode and a configurable memory read latency, and stalls the CPU while busy.

Parameters:
- V, 128, vector width in bits; must be an integer multiple of N.
- N, 32, element and memory data/address width in bits.
- MEM_LAT, 1, memory read latency in cycles (>=1): mem_rdata for a read issued in cycle t is valid in cycle t+MEM_LAT.
- LANES, V/N, derived localparam, not overridable; lane counter width is clog2(LANES), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; latched at start.
- is_vector  in  1  1 = all LANES lanes, 0 = lane 0 only (scalar); latched at start.
- addr_vector  in  V  per-lane addresses, lane i = bits [N*i+N-1 : N*i]; latched at start.
- data_vector  in  V  per-lane store data, same lane mapping; latched at start.
- mem_rdata  in  N  memory read data.
- mem_addr  out  N  memory address.
- mem_wdata  out  N  memory write data.
- mem_wen  out  1  memory write strobe.
- mem_ren  out  1  memory read strobe.
- stall_cpu  out  1  CPU stall.
- done  out  1  one-cycle completion pulse.
- load_vector  out  V  assembled load result (registered).

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset (async, immediate):
  - State goes to IDLE; lane counter and drain counter are 0.
  - load_vector is 0, done is 0.
  - mem_wen, mem_ren and stall_cpu are 0.
  - mem_addr and mem_wdata are 0.
  - Reset asserted mid-operation aborts the operation; no further memory strobes occur.
- IDLE:
  - All memory outputs are 0.
  - stall_cpu = start (combinational), so the CPU is held in the request cycle.
  - On start: latch all operands, clear load_vector to 0, set lane=0, go to ISSUE.
- ISSUE, one lane per cycle:
  - mem_addr = latched address of current lane.
  - Store: mem_wen=1 and mem_wdata = latched data of current lane.
  - Load: mem_ren=1 and mem_wdata=0.
  - Last lane is LANES-1 in vector mode, 0 in scalar mode. After the last lane:
    - Store goes to DONE.
    - Load goes to DRAIN.
  - Otherwise lane increments.
- Load capture:
  - The lane index is delayed through a MEM_LAT-deep pipeline alongside a valid bit.
  - When the delayed valid bit is set, mem_rdata is written into the matching lane of load_vector on that edge.
  - Lanes never accessed (scalar mode) stay 0, i.e. zero-extension.
- DRAIN:
  - Memory strobes are 0.
  - Waits until the last issued read has been captured: exactly MEM_LAT cycles after the last ISSUE cycle, then goes to DONE.
- DONE:
  - done=1 and stall_cpu=0; load_vector is final and held.
  - Next state is IDLE.
  - start in DONE is ignored; the CPU re-requests from IDLE.
- stall_cpu is 1 in ISSUE and DRAIN.
- start while not in IDLE is ignored. Operand input changes after start do not affect the operation.
- Timing, with start in cycle 0:
  - Vector store uses ISSUE cycles 1..LANES and DONE at LANES+1.
  - Vector load uses DONE at LANES+1+MEM_LAT.
  - Scalar store uses DONE at 2; scalar load uses DONE at 2+MEM_LAT.
- load_vector holds its value until the next start.

Test Plan:
- Reset mid-operation: assert rst during the ISSUE cycle of lane 2 of a vector store -> mem_wen drops the same cycle, state is IDLE, load_vector=0, done never pulses; the next start behaves normally.
- Vector store, defaults: addr lanes {0x10,0x14,0x18,0x1C}, data lanes {0xA,0xB,0xC,0xD}, start at cycle 0 -> mem_wen=1 in cycles 1-4 with addr/data pairs in lane order, stall_cpu=1 in cycles 0-4, done=1 in cycle 5.
- Vector load with MEM_LAT=2: memory model returns addr+0x100 -> load_vector = {0x11C,0x118,0x114,0x110} (lane 3..0), done in cycle 7, mem_ren=1 only in cycles 1-4.
- Scalar load: is_vector=0, lane-0 address 0x40, memory returns 0xDEADBEEF -> load_vector = 96'b0 concatenated with 0xDEADBEEF, exactly one mem_ren pulse, done in cycle 2+MEM_LAT.
- Back-to-back and ignored start: hold start high continuously -> operations start only from IDLE, and one idle cycle separates each done from the next ISSUE; operand changes mid-operation have no effect.
- Parameter sweep: V=256, N=32, MEM_LAT=3 -> 8 store writes in order, load done in cycle 12, all 8 lanes correct.
